// File: rtl/media_pulse_multi.sv
// media_pulse_multi
//   Broadcasts soc to NCH converters, waits for the full soc/eoc handshake,
//   averages the captured samples and drives out high for exactly <mean> cycles.
//   Build option: define MEDIA_ROUND_EN for a round-half-up mean; the default
//   build truncates.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | waiting for start (or restarting at once when AUTO=1)
//   SOC_WAIT  | soc high, waiting for every eoc to drop
//   CONV_WAIT | soc low, waiting for every eoc to rise (optional timeout)
//   PULSE     | out high, down-counting the remaining pulse cycles
//   FIN       | pulse finished, done is raised on the way back to IDLE
module media_pulse_multi #(
    parameter int W       = 8,
    parameter int NCH     = 2,
    parameter int AUTO    = 1,
    parameter int TIMEOUT = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [NCH-1:0]   eoc,
    input  logic [NCH*W-1:0] x,
    output logic             soc,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int L  = $clog2(NCH);
    localparam int SW = W + L;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        SOC_WAIT,
        CONV_WAIT,
        PULSE,
        FIN
    } state_t;

    state_t          state_q, state_d;
    logic            soc_q, soc_d;
    logic            out_q, out_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [W-1:0]    count_q, count_d;
    logic [TW-1:0]   tmr_q, tmr_d;

    logic [SW-1:0]   sum;
    logic [SW-1:0]   sum_rnd;
    logic [W-1:0]    mean;
    logic            all_hi;
    logic            all_lo;

    assign all_hi = &eoc;
    assign all_lo = ~|eoc;

    // Channel sum (wide enough to never overflow) and the averaged sample
    always_comb begin
        sum = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = sum + SW'(x[i*W +: W]);
        end
`ifdef MEDIA_ROUND_EN
        sum_rnd = sum + SW'(NCH >> 1);
`else
        sum_rnd = sum;
`endif
        mean = W'(sum_rnd >> L);
    end

    // Next-state and next-output decode of the sequencing FSM
    always_comb begin
        state_d = state_q;
        soc_d   = soc_q;
        out_d   = out_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        count_d = count_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                if (AUTO != 0 || start) begin
                    soc_d   = 1'b1;
                    state_d = SOC_WAIT;
                end
            end
            SOC_WAIT: begin
                if (all_lo) begin
                    soc_d   = 1'b0;
                    tmr_d   = '0;
                    state_d = CONV_WAIT;
                end
            end
            CONV_WAIT: begin
                // Capture outranks a timeout landing on the same edge
                if (all_hi) begin
                    count_d = mean;
                    out_d   = (mean != '0);
                    state_d = (mean != '0) ? PULSE : FIN;
                end else if (TIMEOUT > 0 && tmr_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            PULSE: begin
                count_d = count_q - 1'b1;
                if (count_q == W'(1)) begin
                    out_d   = 1'b0;
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins over everything, even mid-pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            soc_q   <= 1'b0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            soc_q   <= soc_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
            tmr_q   <= tmr_d;
        end
    end

    assign soc  = soc_q;
    assign out  = out_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_media_pulse_multi.sv
// tb_media_pulse_multi
//   Three instances: A (NCH=2, AUTO=0), B (NCH=2, AUTO=0, TIMEOUT=8) and
//   C (NCH=4, AUTO=1). A transaction-level model predicts every output each
//   cycle; directed scenarios add literal pulse-length and timing expectations.
module tb_media_pulse_multi;

`ifdef MEDIA_ROUND_EN
    localparam bit ROUND_ON = 1'b1;
`else
    localparam bit ROUND_ON = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_a = 1'b1, start_a = 1'b0;
    logic [1:0]  eoc_a = '0;
    logic [15:0] x_a   = '0;
    logic        soc_a, out_a, busy_a, done_a, err_a;

    logic        rst_b = 1'b1, start_b = 1'b0;
    logic [1:0]  eoc_b = '0;
    logic [15:0] x_b   = '0;
    logic        soc_b, out_b, busy_b, done_b, err_b;

    logic        rst_c = 1'b1, start_c = 1'b0;
    logic [3:0]  eoc_c = '0;
    logic [31:0] x_c   = {4{8'd255}};
    logic        soc_c, out_c, busy_c, done_c, err_c;

    media_pulse_multi #(.W(8), .NCH(2), .AUTO(0), .TIMEOUT(0)) dut_a (
        .clock(clock), .reset(rst_a), .start(start_a), .eoc(eoc_a), .x(x_a),
        .soc(soc_a), .out(out_a), .busy(busy_a), .done(done_a), .err(err_a));

    media_pulse_multi #(.W(8), .NCH(2), .AUTO(0), .TIMEOUT(8)) dut_b (
        .clock(clock), .reset(rst_b), .start(start_b), .eoc(eoc_b), .x(x_b),
        .soc(soc_b), .out(out_b), .busy(busy_b), .done(done_b), .err(err_b));

    media_pulse_multi #(.W(8), .NCH(4), .AUTO(1), .TIMEOUT(0)) dut_c (
        .clock(clock), .reset(rst_c), .start(start_c), .eoc(eoc_c), .x(x_c),
        .soc(soc_c), .out(out_c), .busy(busy_c), .done(done_c), .err(err_c));

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: phase of the handshake, cycles of pulse still owed, wait timer
    typedef struct packed {
        logic [2:0]  ph;     // 0 idle, 1 soc out, 2 awaiting eoc, 3 pulsing, 4 finishing
        logic [8:0]  left;   // out is high exactly while this is nonzero
        logic [15:0] tmr;
        logic        soc;
        logic        done;
        logic        err;
    } mst_t;

    mst_t ma = '0, mb = '0, mc = '0;

    function automatic int mean_of(input logic [31:0] xv, input int nch);
        int s = 0;
        for (int i = 0; i < nch; i++) s += int'(xv[i*8 +: 8]);
        if (ROUND_ON) return (s + nch / 2) / nch;
        return s / nch;
    endfunction

    function automatic mst_t mstep(input mst_t s, input logic rst, input logic start,
                                   input logic [3:0] eoc, input logic [31:0] xv,
                                   input int nch, input bit auto_m, input int timeout);
        mst_t n = s;
        logic [3:0] mask = 4'((1 << nch) - 1);
        int m;
        n.done = 1'b0;
        n.err  = 1'b0;
        if (rst) return '0;
        case (s.ph)
            3'd0: if (auto_m || start) begin n.soc = 1'b1; n.ph = 3'd1; end
            3'd1: if ((eoc & mask) == 4'd0) begin n.soc = 1'b0; n.tmr = '0; n.ph = 3'd2; end
            3'd2: begin
                if ((eoc & mask) == mask) begin
                    m = mean_of(xv, nch);
                    n.left = 9'(m);
                    n.ph = (m != 0) ? 3'd3 : 3'd4;
                end else if (timeout > 0 && int'(s.tmr) == timeout - 1) begin
                    n.err = 1'b1;
                    n.ph = 3'd0;
                end else begin
                    n.tmr = s.tmr + 16'd1;
                end
            end
            3'd3: begin
                n.left = s.left - 9'd1;
                if (s.left == 9'd1) n.ph = 3'd4;
            end
            default: begin n.done = 1'b1; n.ph = 3'd0; end
        endcase
        return n;
    endfunction

    // Advance the model on the same edge the DUTs sample
    always @(posedge clock) begin
        ma <= mstep(ma, rst_a, start_a, {2'b00, eoc_a}, {16'h0, x_a}, 2, 1'b0, 0);
        mb <= mstep(mb, rst_b, start_b, {2'b00, eoc_b}, {16'h0, x_b}, 2, 1'b0, 8);
        mc <= mstep(mc, rst_c, start_c, eoc_c, x_c, 4, 1'b1, 0);
    end

    task automatic cmp_inst(input string tag, input logic soc, input logic out, input logic busy,
                            input logic done, input logic err, input mst_t m);
        chk({tag, "_soc"},  {31'b0, soc},  {31'b0, m.soc});
        chk({tag, "_out"},  {31'b0, out},  {31'b0, (m.left != 9'd0)});
        chk({tag, "_busy"}, {31'b0, busy}, {31'b0, (m.ph != 3'd0)});
        chk({tag, "_done"}, {31'b0, done}, {31'b0, m.done});
        chk({tag, "_err"},  {31'b0, err},  {31'b0, m.err});
    endtask

    // Every-cycle comparison against the model, away from the sampling edge
    always @(negedge clock) begin
        if (armed) begin
            cmp_inst("a", soc_a, out_a, busy_a, done_a, err_a, ma);
            cmp_inst("b", soc_b, out_b, busy_b, done_b, err_b, mb);
            cmp_inst("c", soc_c, out_c, busy_c, done_c, err_c, mc);
        end
    end

    // Count out-high cycles until done (bounded)
    task automatic measure(input int which, output int n, output bit got, output bit saw_err);
        logic o, d, e;
        n = 0; got = 1'b0; saw_err = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            case (which)
                0:       begin o = out_a; d = done_a; e = err_a; end
                1:       begin o = out_b; d = done_b; e = err_b; end
                default: begin o = out_c; d = done_c; e = err_c; end
            endcase
            if (o) n++;
            if (e) saw_err = 1'b1;
            if (d) begin got = 1'b1; break; end
        end
    endtask

    task automatic conv_a(input string tag, input logic [15:0] xv, input logic [1:0] mid,
                          input int mid_n, input int exp_len);
        int n; bit got, e;
        x_a = xv; eoc_a = 2'b11; start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (soc_a) begin got = 1'b1; break; end
            @(negedge clock);
        end
        chk({tag, "_soc_rise"}, {31'b0, got}, 32'd1);
        eoc_a = 2'b00;
        @(negedge clock);
        chk({tag, "_soc_fall"}, {31'b0, soc_a}, 32'd0);
        eoc_a = mid;
        repeat (mid_n) @(negedge clock);
        eoc_a = 2'b11;
        measure(0, n, got, e);
        chk({tag, "_done"}, {31'b0, got}, 32'd1);
        chk({tag, "_len"}, n, exp_len);
        chk({tag, "_idle"}, {31'b0, busy_a}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1);
    end

    initial begin
        int n, k; bit got, e, any;
        @(negedge clock);
        armed = 1'b1;
        @(negedge clock);
        chk("rst_soc_a", {31'b0, soc_a}, 32'd0);
        chk("rst_busy_c", {31'b0, busy_c}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        any = 1'b0;
        repeat (4) begin @(negedge clock); any |= soc_a; end
        chk("a_no_soc_wo_start", {31'b0, any}, 32'd0);

        // Instance A: averaging, truncation/rounding, zero mean, mixed eoc
        conv_a("a_10_20", {8'd20, 8'd10}, 2'b00, 0, 15);
        conv_a("a_3_4",   {8'd4, 8'd3},   2'b00, 0, ROUND_ON ? 4 : 3);
        conv_a("a_0_1",   {8'd1, 8'd0},   2'b00, 0, ROUND_ON ? 1 : 0);
        conv_a("a_mixed", {8'd50, 8'd100}, 2'b01, 20, 75);

        // start held high behaves like free-running
        start_a = 1'b1; x_a = {8'd2, 8'd2}; eoc_a = 2'b11;
        @(negedge clock);
        eoc_a = 2'b00;
        @(negedge clock);
        eoc_a = 2'b11;
        measure(0, n, got, e);
        chk("a_hold_len", n, 2);
        @(negedge clock);
        chk("a_hold_resoc", {31'b0, soc_a}, 32'd1);
        start_a = 1'b0;

        // Reset mid-pulse, then no restart without start
        x_a = {8'd200, 8'd200}; eoc_a = 2'b00;
        @(negedge clock);
        eoc_a = 2'b11;
        repeat (50) @(negedge clock);
        chk("a_mid_out", {31'b0, out_a}, 32'd1);
        rst_a = 1'b1;
        @(negedge clock);
        chk("a_rst_out", {31'b0, out_a}, 32'd0);
        chk("a_rst_soc", {31'b0, soc_a}, 32'd0);
        chk("a_rst_busy", {31'b0, busy_a}, 32'd0);
        rst_a = 1'b0;
        any = 1'b0;
        repeat (10) begin @(negedge clock); any |= soc_a; end
        chk("a_post_rst_no_soc", {31'b0, any}, 32'd0);
        conv_a("a_7_9", {8'd9, 8'd7}, 2'b00, 0, 8);

        // Instance B: timeout with eoc stuck low
        start_b = 1'b1; eoc_b = 2'b11;
        @(negedge clock);
        start_b = 1'b0; eoc_b = 2'b00;
        @(negedge clock);
        k = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            k++;
            if (err_b) begin got = 1'b1; break; end
        end
        chk("b_err_seen", {31'b0, got}, 32'd1);
        chk("b_err_delay", k, 8);
        chk("b_err_soc", {31'b0, soc_b}, 32'd0);
        chk("b_err_busy", {31'b0, busy_b}, 32'd0);
        @(negedge clock);
        chk("b_err_onecycle", {31'b0, err_b}, 32'd0);

        // Capture on the very edge the timeout would fire: capture wins
        x_b = {8'd8, 8'd6};
        start_b = 1'b1; eoc_b = 2'b11;
        @(negedge clock);
        start_b = 1'b0; eoc_b = 2'b00;
        @(negedge clock);
        repeat (7) @(negedge clock);
        eoc_b = 2'b11;
        measure(1, n, got, e);
        chk("b_race_done", {31'b0, got}, 32'd1);
        chk("b_race_noerr", {31'b0, e}, 32'd0);
        chk("b_race_len", n, 7);

        // Instance C: four channels, free-running, already waiting on eoc
        x_c = {8'd4, 8'd3, 8'd2, 8'd1}; eoc_c = 4'b0111;
        repeat (5) @(negedge clock);
        eoc_c = 4'hF;
        measure(2, n, got, e);
        chk("c_1234_len", n, ROUND_ON ? 3 : 2);
        @(negedge clock);
        chk("c_auto_resoc", {31'b0, soc_c}, 32'd1);

        x_c = {4{8'd255}}; eoc_c = 4'h0;
        @(negedge clock);
        eoc_c = 4'hF;
        measure(2, n, got, e);
        chk("c_255_done", {31'b0, got}, 32'd1);
        chk("c_255_len", n, 255);
        @(negedge clock);
        chk("c_255_resoc", {31'b0, soc_c}, 32'd1);

        eoc_c = 4'h0;
        @(negedge clock);
        eoc_c = 4'hF;
        repeat (156) @(negedge clock);
        chk("c_mid_out", {31'b0, out_c}, 32'd1);
        rst_c = 1'b1;
        @(negedge clock);
        chk("c_rst_out", {31'b0, out_c}, 32'd0);
        chk("c_rst_soc", {31'b0, soc_c}, 32'd0);
        chk("c_rst_busy", {31'b0, busy_c}, 32'd0);
        rst_c = 1'b0;
        @(negedge clock);
        chk("c_auto_after_rst", {31'b0, soc_c}, 32'd1);

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
